decoder_slot_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 16-way one-hot select bus among 16 requesters.

---
 rtl/decoder_slot_arbiter.sv | 137 +++++++++++++
 tb/tb_decoder_slot_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_slot_arbiter.sv
// Round-robin arbiter sharing one 16-way one-hot select bus among 16 requesters,
// with per-grant hold timeout and a post-grant turnaround gap.
module decoder_slot_arbiter #(
   parameter int MAX_HOLD   = 200,
   parameter int HOLD_W     = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] req,
   output logic        gnt_valid,
   output logic [3:0]  gnt_idx,
   output logic [15:0] gnt_onehot,
   output logic        timeout,
   output logic        busy
);

   localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
   localparam logic [GAP_W-1:0]  GAP_C      = GAP_W'(GAP_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                valid_q, valid_d;
   logic [3:0]          idx_q, idx_d;
   logic                timeout_q, timeout_d;
   logic                busy_q, busy_d;

   logic                win_found;
   logic [3:0]          win_idx;
   logic [3:0]          cand;

   function automatic logic [15:0] decoder_4_16(input logic [3:0] idx);
      return 16'h0001 << idx;
   endfunction

   // Scan from the highest offset down so the slot closest to ptr wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int k = 15; k >= 0; k--) begin
         cand = ptr_q + 4'(k);
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      gap_d     = gap_q;
      valid_d   = valid_q;
      idx_d     = idx_q;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en && win_found) begin
               state_d = S_GRANT;
               idx_d   = win_idx;
               valid_d = 1'b1;
               hold_d  = HOLD_W'(1);
            end
         end
         S_GRANT: begin
            // Release takes precedence over a timeout falling on the same edge.
            if (!req[idx_q]) begin
               state_d = S_GAP;
               valid_d = 1'b0;
               ptr_d   = idx_q + 4'd1;
               gap_d   = GAP_W'(1);
            end else if ((MAX_HOLD != 0) && (hold_q == MAX_HOLD_C)) begin
               state_d   = S_GAP;
               valid_d   = 1'b0;
               ptr_d     = idx_q + 4'd1;
               gap_d     = GAP_W'(1);
               timeout_d = 1'b1;
            end else if (hold_q != '1) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         S_GAP: begin
            if (gap_q >= GAP_C) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= 4'd0;
         hold_q    <= '0;
         gap_q     <= '0;
         valid_q   <= 1'b0;
         idx_q     <= 4'd0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gap_q     <= gap_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   assign gnt_valid  = valid_q;
   assign gnt_idx    = idx_q;
   assign gnt_onehot = valid_q ? decoder_4_16(idx_q) : 16'h0000;
   assign timeout    = timeout_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_decoder_slot_arbiter.sv
// Directed bench for decoder_slot_arbiter: reset, round robin, wrap, timeout,
// enable gating and asynchronous reset during a grant.
module tb_decoder_slot_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] req;
   logic        gnt_valid;
   logic [3:0]  gnt_idx;
   logic [15:0] gnt_onehot;
   logic        timeout;
   logic        busy;

   int passed = 0;
   int total  = 0;

   decoder_slot_arbiter #(
      .MAX_HOLD  (4),
      .HOLD_W    (8),
      .GAP_CYCLES(1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx),
      .gnt_onehot(gnt_onehot),
      .timeout   (timeout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Entered in IDLE with req already at mask: grant, hold 3 cycles, release, GAP, IDLE.
   task automatic grant_cycle(input string tag, input logic [3:0] exp_idx, input logic [15:0] mask);
      logic [15:0] bit_m;
      bit_m = 16'h0001 << exp_idx;
      step();
      chk({tag, ".valid"}, 32'(gnt_valid), 32'd1);
      chk({tag, ".idx"}, 32'(gnt_idx), 32'(exp_idx));
      chk({tag, ".onehot"}, 32'(gnt_onehot), 32'(bit_m));
      step();
      step();
      chk({tag, ".held"}, 32'(gnt_valid), 32'd1);
      req = mask & ~bit_m;
      step();
      chk({tag, ".gap_valid"}, 32'(gnt_valid), 32'd0);
      chk({tag, ".gap_busy"}, 32'(busy), 32'd1);
      chk({tag, ".gap_onehot"}, 32'(gnt_onehot), 32'd0);
      req = mask;
      step();
      chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      req = 16'h0000;
      #1;
      chk("rst.valid", 32'(gnt_valid), 32'd0);
      chk("rst.idx", 32'(gnt_idx), 32'd0);
      chk("rst.onehot", 32'(gnt_onehot), 32'd0);
      chk("rst.timeout", 32'(timeout), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      step();
      step();
      rst = 1'b0;

      // Single requester
      en  = 1'b1;
      req = 16'h0001;
      grant_cycle("t1", 4'd0, 16'h0001);

      // Round robin from ptr=0
      rst = 1'b1;
      req = 16'h0000;
      step();
      rst = 1'b0;
      req = 16'h8005;
      grant_cycle("rr0", 4'd0, 16'h8005);
      grant_cycle("rr2", 4'd2, 16'h8005);
      grant_cycle("rr15", 4'd15, 16'h8005);
      grant_cycle("rr0b", 4'd0, 16'h8005);

      // Wrap-around: after 14, slot 15 precedes slot 0
      req = 16'h4000;
      grant_cycle("w14", 4'd14, 16'h4000);
      req = 16'h8001;
      grant_cycle("w15", 4'd15, 16'h8001);
      grant_cycle("w0", 4'd0, 16'h8001);

      // Timeout at MAX_HOLD=4, ptr=1
      req = 16'h0020;
      step();
      chk("to.g1", 32'(gnt_idx), 32'd5);
      step();
      chk("to.g2", 32'(gnt_valid), 32'd1);
      step();
      chk("to.g3", 32'(gnt_valid), 32'd1);
      step();
      chk("to.g4", 32'(gnt_valid), 32'd1);
      chk("to.g4_nopulse", 32'(timeout), 32'd0);
      step();
      chk("to.revoked", 32'(gnt_valid), 32'd0);
      chk("to.pulse", 32'(timeout), 32'd1);
      chk("to.busy", 32'(busy), 32'd1);
      step();
      chk("to.pulse_end", 32'(timeout), 32'd0);
      chk("to.idle_valid", 32'(gnt_valid), 32'd0);
      step();
      chk("to.regrant_v", 32'(gnt_valid), 32'd1);
      chk("to.regrant_i", 32'(gnt_idx), 32'd5);
      step();
      step();
      step();
      req = 16'h0000;
      step();
      chk("to.rel_same_edge_v", 32'(gnt_valid), 32'd0);
      chk("to.rel_same_edge_t", 32'(timeout), 32'd0);
      step();

      // en gating, ptr=6
      en  = 1'b0;
      req = 16'hFFFF;
      step();
      step();
      step();
      chk("en0.valid", 32'(gnt_valid), 32'd0);
      chk("en0.busy", 32'(busy), 32'd0);
      en = 1'b1;
      step();
      chk("en1.idx", 32'(gnt_idx), 32'd6);
      chk("en1.valid", 32'(gnt_valid), 32'd1);
      en = 1'b0;
      step();
      step();
      chk("endrop.held", 32'(gnt_valid), 32'd1);
      req = 16'hFFBF;
      step();
      chk("endrop.gap", 32'(gnt_valid), 32'd0);
      step();
      step();
      chk("endrop.nogrant", 32'(gnt_valid), 32'd0);
      chk("endrop.idle", 32'(busy), 32'd0);

      // Asynchronous reset mid-grant, ptr=7
      en  = 1'b1;
      req = 16'hFFFF;
      step();
      chk("ar.pre_idx", 32'(gnt_idx), 32'd7);
      #3;
      rst = 1'b1;
      #1;
      chk("ar.valid", 32'(gnt_valid), 32'd0);
      chk("ar.onehot", 32'(gnt_onehot), 32'd0);
      chk("ar.busy", 32'(busy), 32'd0);
      req = 16'h0003;
      step();
      rst = 1'b0;
      step();
      chk("ar.post_valid", 32'(gnt_valid), 32'd1);
      chk("ar.post_idx", 32'(gnt_idx), 32'd0);
      chk("ar.post_onehot", 32'(gnt_onehot), 32'h0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
